pe_wg_feeder: RTL and testbench



---
 rtl/pe_wg_pkg.sv | 17 +
 rtl/pe_wg_line_buf.sv | 32 +++
 rtl/pe_wg_feeder.sv | 168 ++++++++++++++++
 tb/tb_pe_wg_feeder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_wg_pkg.sv
// Shared definitions for the weight-gradient PE feeder and its collector:
// feeder FSM state encoding, default activation width, column counter width
// for the default row length, and the partial-sum width seen downstream.
package pe_wg_pkg;

  localparam int N_DEF       = 8;
  localparam int ROW_LEN_DEF = 8;
  localparam int COL_W       = $clog2(ROW_LEN_DEF);
  localparam int PSUM_W      = 2 * N_DEF + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/pe_wg_line_buf.sv
// One-row line buffer: ROW_LEN x N circular store addressed by column.
// A single address is read-before-write: the registered read returns the
// pixel stored one row earlier at that column, then the new pixel replaces it.
// Storage is not reset; only the read register is, so i1 comes up as zero.
module pe_wg_line_buf #(
  parameter int N       = 8,
  parameter int ROW_LEN = 8,
  parameter int AW      = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          zero,
  input  logic [AW-1:0] addr,
  input  logic [N-1:0]  wr_data,
  output logic [N-1:0]  rd_data
);

  logic [N-1:0] mem [ROW_LEN];

  // Storage write on every accepted pixel.
  always_ff @(posedge clk) begin
    if (en) mem[addr] <= wr_data;
  end

  // Registered read of the old contents; forced to zero on the first row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rd_data <= '0;
    else if (en)   rd_data <= zero ? '0 : mem[addr];
  end

endmodule

// File: rtl/pe_wg_feeder.sv
// Upstream feeder for the 3-tap weight-gradient PE. Accepts a raster pixel
// stream, keeps one row in pe_wg_line_buf and presents current/previous-row
// pixels, weights and tap selects to the PE one cycle after acceptance.
// Non-pixel cycles carry zero weights so the PE accumulators stay clean.
// Optional feature macro: PE_WG_FEEDER_STATS_EN adds the stall_cnt output.
module pe_wg_feeder
  import pe_wg_pkg::*;
#(
  parameter int N            = N_DEF,
  parameter int ROW_LEN      = 8,
  parameter int ROW_W        = 8,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [ROW_W-1:0] cfg_rows,
  input  logic [3*N-1:0]   w_in,
  input  logic [N-1:0]     act_data,
  input  logic             act_valid,
  output logic             act_ready,
  output logic [N-1:0]     i0,
  output logic [N-1:0]     i1,
  output logic [N-1:0]     w0,
  output logic [N-1:0]     w1,
  output logic [N-1:0]     w2,
  output logic             select0,
  output logic             select1,
  output logic             busy,
  output logic             done
`ifdef PE_WG_FEEDER_STATS_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int CW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0]    COL_LAST = CW'(ROW_LEN - 1);
  localparam logic [CW-1:0]    COL_ONE  = CW'(1);
  localparam logic [FW-1:0]    FL_LAST  = FW'(FLUSH_CYCLES - 1);
  localparam logic [FW-1:0]    FL_ONE   = FW'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  state_t           state;
  logic [CW-1:0]    col;
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] rows_lat;
  logic [FW-1:0]    fcnt;
  logic [3*N-1:0]   w_lat;
  logic             accept;
  logic             start_ok;

  // A start is honoured only in IDLE and not in the done-pulse cycle.
  assign start_ok = (state == IDLE) && start && !done;
  assign accept   = (state == RUN) && act_valid && act_ready;

  // Frame control FSM with registered handshake/status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      rows_lat  <= '0;
      fcnt      <= '0;
      act_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            rows_lat <= cfg_rows;
            col      <= '0;
            row      <= '0;
            fcnt     <= '0;
            busy     <= 1'b1;
            if (cfg_rows == '0) begin
              state <= FLUSH;
            end else begin
              state     <= RUN;
              act_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + ROW_ONE;
              if (row == rows_lat - ROW_ONE) begin
                state     <= FLUSH;
                act_ready <= 1'b0;
              end
            end else begin
              col <= col + COL_ONE;
            end
          end
        end
        FLUSH: begin
          if (fcnt == FL_LAST) begin
            fcnt  <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            fcnt <= fcnt + FL_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Weight capture at frame start; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (start_ok) w_lat <= w_in;
  end

  // PE-facing pixel/weight/select registers; weights drop to zero when no pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i0      <= '0;
      w0      <= '0;
      w1      <= '0;
      w2      <= '0;
      select0 <= 1'b0;
      select1 <= 1'b0;
    end else if (accept) begin
      i0      <= act_data;
      w0      <= w_lat[N-1:0];
      w1      <= w_lat[2*N-1:N];
      w2      <= w_lat[3*N-1:2*N];
      select0 <= (row != '0);
      select1 <= (col != '0);
    end else begin
      w0 <= '0;
      w1 <= '0;
      w2 <= '0;
    end
  end

  pe_wg_line_buf #(
    .N       (N),
    .ROW_LEN (ROW_LEN),
    .AW      (CW)
  ) u_line_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (accept),
    .zero    (row == '0),
    .addr    (col),
    .wr_data (act_data),
    .rd_data (i1)
  );

`ifdef PE_WG_FEEDER_STATS_EN
  // Saturating count of RUN cycles with no pixel offered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  stall_cnt <= '0;
    else if (start_ok)             stall_cnt <= '0;
    else if ((state == RUN) && !act_valid && (stall_cnt != 16'hFFFF))
                                   stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pe_wg_feeder.sv
// Self-checking bench for pe_wg_feeder: a driver pushes the expected PE-side
// beat for every accepted pixel into a scoreboard queue; a negedge monitor
// pops and compares whenever the feeder presents non-zero weights.
module tb_pe_wg_feeder;

  localparam int N  = 8;
  localparam int RL = 4;
  localparam int RW = 8;
  localparam int FC = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [RW-1:0] cfg_rows = '0;
  logic [3*N-1:0] w_in = '0;
  logic [N-1:0]  act_data = '0;
  logic          act_valid = 1'b0;
  logic          act_ready;
  logic [N-1:0]  i0, i1, w0, w1, w2;
  logic          select0, select1, busy, done;
`ifdef PE_WG_FEEDER_STATS_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  pe_wg_feeder #(
    .N(N), .ROW_LEN(RL), .ROW_W(RW), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg_rows(cfg_rows),
    .w_in(w_in), .act_data(act_data), .act_valid(act_valid),
    .act_ready(act_ready), .i0(i0), .i1(i1), .w0(w0), .w1(w1), .w2(w2),
    .select0(select0), .select1(select1), .busy(busy), .done(done)
`ifdef PE_WG_FEEDER_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    logic [N-1:0] i0, i1, w0, w1, w2;
    logic         s0, s1;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur", name);
  endtask

  // Monitor / scoreboard
  exp_t          mon_e;
  int            since_pix = 0;
  int            frame_pix = 0;
  int            flush_run = 0;
  logic [N-1:0]  last_i0 = '0;
  bit            have_last = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      have_last = 1'b0;
      frame_pix = 0;
      flush_run = 0;
      since_pix = 0;
    end else begin
      if ((w0 | w1 | w2) != '0) begin
        if (q.size() == 0) begin
          fail_now("unexpected_pixel_beat");
        end else begin
          mon_e = q.pop_front();
          chk("i0", i0, mon_e.i0);
          chk("i1", i1, mon_e.i1);
          chk("w0", w0, mon_e.w0);
          chk("w1", w1, mon_e.w1);
          chk("w2", w2, mon_e.w2);
          chk("select0", select0, mon_e.s0);
          chk("select1", select1, mon_e.s1);
        end
        last_i0   = i0;
        have_last = 1'b1;
        since_pix = 0;
        frame_pix++;
      end else begin
        since_pix++;
        if (busy && have_last && frame_pix > 0) chk("i0_hold", i0, last_i0);
      end
      if (busy && !act_ready) flush_run++;
      if (done) begin
        done_cnt++;
        chk("flush_len", flush_run, FC);
        chk("busy_at_done", busy, 1'b0);
        chk("queue_empty_at_done", q.size(), 0);
        if (frame_pix > 0) chk("done_gap", since_pix, FC);
        frame_pix = 0;
        flush_run = 0;
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_i0"}, i0, 0);
    chk({tag, "_i1"}, i1, 0);
    chk({tag, "_w"}, {w2, w1, w0}, 0);
    chk({tag, "_sel"}, {select1, select0}, 0);
    chk({tag, "_ctl"}, {act_ready, busy, done}, 0);
  endtask

  // Drive one frame; abort_after>=0 stops offering pixels after that many.
  task automatic run_frame(input int rows, input logic [N-1:0] wa, input logic [N-1:0] wb,
                           input logic [N-1:0] wc, input bit seq_data, input int bub_pct,
                           input int bub_after, input int bub_len, input bit hold_start,
                           input int abort_after);
    logic [N-1:0] pix[$];
    exp_t e;
    int total, k, b, guard, bubbles, row, col;
    bit got_done, bubble;
    total = rows * RL;
    k = 0; b = 0; guard = 0; bubbles = 0;
    for (int i = 0; i < total; i++) pix.push_back(seq_data ? N'(i + 1) : N'($urandom));
    @(negedge clk);
    cfg_rows = RW'(rows);
    w_in = {wc, wb, wa};
    start = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
`ifdef PE_WG_FEEDER_STATS_EN
    chk("stall_cnt_cleared", stall_cnt, 0);
`endif
    while (k < total) begin
      if (abort_after >= 0 && k == abort_after) break;
      bubble = 1'b0;
      if (k == bub_after && b < bub_len) begin
        bubble = 1'b1;
        b++;
        chk("ready_in_bubble", act_ready, 1'b1);
      end else if (int'($urandom_range(0, 99)) < bub_pct) begin
        bubble = 1'b1;
      end
      if (bubble) begin
        act_valid = 1'b0;
        if (act_ready) bubbles++;
      end else begin
        act_valid = 1'b1;
        act_data  = pix[k];
        if (act_ready) begin
          row  = k / RL;
          col  = k % RL;
          e.i0 = pix[k];
          e.i1 = (row == 0) ? '0 : pix[k - RL];
          e.w0 = wa; e.w1 = wb; e.w2 = wc;
          e.s0 = (row != 0);
          e.s1 = (col != 0);
          q.push_back(e);
          k++;
        end
      end
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        fail_now("pixel_accept_timeout");
        break;
      end
    end
    act_valid = 1'b0;
    if (abort_after >= 0 && k == abort_after) return;
    got_done = 1'b0;
    for (int c = 0; c < 100 && !got_done; c++) begin
      if (done) begin
        got_done = 1'b1;
        if (hold_start) start = 1'b0;
`ifdef PE_WG_FEEDER_STATS_EN
        chk("stall_cnt_at_done", stall_cnt, bubbles);
`endif
      end else begin
        chk("ready_low_after_last", act_ready, 1'b0);
        @(negedge clk);
      end
    end
    if (!got_done) fail_now("done_timeout");
    start = 1'b0;
    @(negedge clk);
  endtask

  int exp_done;
  int dc;

  initial begin
    exp_done = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    // Plain frame, pixels 1..8
    run_frame(2, 8'd1, 8'd2, 8'd3, 1'b1, 0, -1, 0, 1'b0, -1);
    exp_done++;
    chk("done_count_plain", done_cnt, exp_done);

    // Same frame with a 3-cycle bubble after pixel 3
    run_frame(2, 8'd1, 8'd2, 8'd3, 1'b1, 0, 3, 3, 1'b0, -1);
    exp_done++;
    chk("done_count_bubble", done_cnt, exp_done);

    // Empty frame
    run_frame(0, 8'd1, 8'd2, 8'd3, 1'b1, 0, -1, 0, 1'b0, -1);
    exp_done++;
    chk("done_count_empty", done_cnt, exp_done);

    // Reset mid-row after pixel 6
    run_frame(2, 8'd4, 8'd5, 8'd6, 1'b1, 0, -1, 0, 1'b0, 6);
    for (int c = 0; c < 10 && q.size() != 0; c++) @(negedge clk);
    chk("queue_drained_before_reset", q.size(), 0);
    dc = done_cnt;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("no_done_on_reset", done_cnt, dc);
    run_frame(3, 8'd7, 8'd9, 8'd11, 1'b0, 0, -1, 0, 1'b0, -1);
    exp_done++;
    chk("done_count_after_reset", done_cnt, exp_done);

    // start held for the whole frame
    run_frame(2, 8'd2, 8'd4, 8'd6, 1'b0, 20, -1, 0, 1'b1, -1);
    exp_done++;
    repeat (6) @(negedge clk);
    chk("held_start_busy", busy, 1'b0);
    chk("done_count_held", done_cnt, exp_done);

    // Random frames with random bubbles
    for (int f = 0; f < 6; f++) begin
      run_frame(int'($urandom_range(1, 4)), N'($urandom_range(1, 255)),
                N'($urandom_range(1, 255)), N'($urandom_range(1, 255)),
                1'b0, 30, int'($urandom_range(0, 7)), 5, 1'b0, -1);
      exp_done++;
    end
    chk("done_count_random", done_cnt, exp_done);
    chk("queue_empty_end", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
